disp_sched: RTL and testbench
=============================

DISP_SCHED -- requirements
Module: disp_sched

Interface
REQ-001 Parameter HOLD_TICKS, 400, lap-display hold length in clk_200Hz cycles (2 s).
REQ-002 Parameter MSG_TICKS, 600, message-display length in clk_200Hz cycles (3 s).
REQ-003 Parameter BLINK_HALF, 40, message blink half-period in clk_200Hz cycles.
REQ-004 clk_200Hz  in  1  sole clock, digit-scan rate of the display driver.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 run_data  in  16  live stopwatch time, 4 BCD/hex nibbles, digit 0 in [3:0].
REQ-007 run_dots  in  4  live decimal points, active-low (1 = off).
REQ-008 lap_req  in  1  level request to show a lap value; held until lap_ack.
REQ-009 lap_data  in  16  lap value, valid while lap_req=1.
REQ-010 msg_req  in  1  level request to show a message; held until msg_ack.
REQ-011 msg_data  in  16  message nibbles, valid while msg_req=1.
REQ-012 msg_dots  in  4  message decimal points, active-low.
REQ-013 data  out  16  registered nibbles to the display driver.
REQ-014 dots  out  4  registered decimal points to the display driver.
REQ-015 EN  out  1  registered display enable (0 = all segments off).
REQ-016 lap_ack, msg_ack  out  1 each  one-cycle acceptance pulses.
REQ-017 src  out  2  current source: 0 RUN, 1 LAP, 2 MSG.

Function
REQ-018 FSM states SHALL be RUN, LAP, MSG; one shared 10-bit down-counter SHALL time LAP and MSG.
REQ-019 In RUN, data/dots SHALL follow run_data/run_dots with one cycle latency and EN=1.
REQ-020 From RUN or LAP, msg_req=1 SHALL take precedence: pulse msg_ack, latch msg_data/msg_dots, load MSG_TICKS-1, enter MSG.
REQ-021 From RUN, lap_req=1 with msg_req=0 SHALL pulse lap_ack, latch lap_data, load HOLD_TICKS-1, enter LAP; dots SHALL show 4'b1111.
REQ-022 In LAP, lap_req=1 (new request) SHALL re-latch lap_data, re-ack, and restart the counter.
REQ-023 In LAP, msg_req=1 SHALL preempt; the lap hold is discarded, not resumed.
REQ-024 In MSG, lap_req and msg_req SHALL not be acked; they remain pending and are served on return to RUN.
REQ-025 Counter reaching 0 SHALL return to RUN on the next edge; display outputs SHALL show run_data one cycle later.
REQ-026 Simultaneous lap_req and msg_req SHALL serve msg first; lap served after MSG ends if still held.
REQ-027 Acks SHALL be registered, asserted exactly one cycle per acceptance, never both in the same cycle.
REQ-028 Latched data SHALL be stable throughout LAP/MSG regardless of input changes.

Reset
REQ-029 rst=1 SHALL immediately force state RUN, counter 0, data 16'h0000, dots 4'b1111, EN 0, acks 0, src 0.
REQ-030 rst asserted mid-LAP or mid-MSG SHALL abort without ack; a still-held request is re-served after release.
REQ-031 First edge after rst release SHALL load run_data/run_dots and set EN=1.

Configuration
REQ-032 With DISP_SCHED_BLINK_EN defined, in MSG EN SHALL toggle every BLINK_HALF cycles starting at 1 on entry, via a separate 6-bit blink counter.
REQ-033 Without DISP_SCHED_BLINK_EN, EN SHALL be held 1 in MSG and no blink counter SHALL exist.

Structure
REQ-034 Shared package disp_pkg SHALL hold the source/state encodings (RUN=0, LAP=1, MSG=2) and blank-dots constant 4'b1111.
REQ-035 Sub-module disp_tick_cnt (loadable down-counter with zero flag) SHALL be instantiated for the hold/message timer; output feeds the existing display driver unchanged.

Verification
REQ-036 run_data=16'h1234, no requests -> data=16'h1234, EN=1, src=0 one cycle after change.
REQ-037 lap_req with lap_data=16'h0059 for 1 cycle -> lap_ack 1 cycle, data=16'h0059 for exactly 400 cycles, dots=4'b1111, then run_data.
REQ-038 lap_req and msg_req together -> msg_ack first, MSG for 600 cycles, then lap_ack and 400-cycle LAP.
REQ-039 msg_req 100 cycles into LAP -> msg_ack, src=2; no return to LAP afterwards if lap_req low.
REQ-040 With DISP_SCHED_BLINK_EN, msg of 16'hE0F0 -> EN 1 for 40 cycles, 0 for 40, repeating; without macro EN=1 for all 600.
REQ-041 rst pulse 200 cycles into MSG -> outputs at reset values asynchronously, run_data shown after release, no ack emitted.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared encodings for the display scheduler: source/state codes and the blank-dots pattern.
package disp_pkg;

    typedef enum logic [1:0] {
        SRC_RUN = 2'd0,
        SRC_LAP = 2'd1,
        SRC_MSG = 2'd2
    } disp_src_e;

    localparam logic [3:0] DOTS_BLANK = 4'b1111;
    localparam int unsigned TICK_W    = 10;
    localparam int unsigned BLINK_W   = 6;

endpackage

// File: rtl/disp_tick_cnt.sv
// Loadable down-counter with zero flag; times the lap hold and message windows.
module disp_tick_cnt #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/disp_sched.sv
// Display source scheduler: live run time, held lap value, or message; one shared timer.
// Optional message blinking is built when DISP_SCHED_BLINK_EN is defined.
//
// state | meaning
// RUN   | show live run_data/run_dots, accept lap/msg requests
// LAP   | hold latched lap value with blank dots for HOLD_TICKS cycles
// MSG   | show latched message for MSG_TICKS cycles, requests stay pending
module disp_sched
    import disp_pkg::*;
#(
    parameter int unsigned HOLD_TICKS = 400,
    parameter int unsigned MSG_TICKS  = 600,
    parameter int unsigned BLINK_HALF = 40
) (
    input  logic        clk_200Hz,
    input  logic        rst,
    input  logic [15:0] run_data,
    input  logic [3:0]  run_dots,
    input  logic        lap_req,
    input  logic [15:0] lap_data,
    input  logic        msg_req,
    input  logic [15:0] msg_data,
    input  logic [3:0]  msg_dots,
    output logic [15:0] data,
    output logic [3:0]  dots,
    output logic        EN,
    output logic        lap_ack,
    output logic        msg_ack,
    output logic [1:0]  src
);

    disp_src_e         state, state_nxt;
    logic [15:0]       data_nxt;
    logic [3:0]        dots_nxt;
    logic              en_nxt;
    logic              lap_ack_nxt;
    logic              msg_ack_nxt;
    logic              cnt_load;
    logic [TICK_W-1:0] cnt_load_val;
    logic              cnt_dec;
    logic              cnt_zero;
    logic              take_msg;
    logic              take_lap;

`ifdef DISP_SCHED_BLINK_EN
    logic [BLINK_W-1:0] blink_cnt, blink_nxt;
`endif

    // A requester still holds lap_req during the ack cycle; ignore it then so one request gets one ack.
    assign take_msg = msg_req && (state != SRC_MSG);
    assign take_lap = lap_req && !msg_req &&
                      ((state == SRC_RUN) || ((state == SRC_LAP) && !lap_ack));
    assign cnt_dec  = (state != SRC_RUN);

    disp_tick_cnt #(.W(TICK_W)) u_tick_cnt (
        .clk      (clk_200Hz),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt    = state;
        data_nxt     = data;
        dots_nxt     = dots;
        en_nxt       = EN;
        lap_ack_nxt  = 1'b0;
        msg_ack_nxt  = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
`ifdef DISP_SCHED_BLINK_EN
        blink_nxt    = blink_cnt;
`endif
        if (take_msg) begin
            state_nxt    = SRC_MSG;
            data_nxt     = msg_data;
            dots_nxt     = msg_dots;
            en_nxt       = 1'b1;
            msg_ack_nxt  = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = TICK_W'(MSG_TICKS - 1);
`ifdef DISP_SCHED_BLINK_EN
            blink_nxt    = BLINK_W'(BLINK_HALF - 1);
`endif
        end else if (take_lap) begin
            state_nxt    = SRC_LAP;
            data_nxt     = lap_data;
            dots_nxt     = DOTS_BLANK;
            en_nxt       = 1'b1;
            lap_ack_nxt  = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = TICK_W'(HOLD_TICKS - 1);
        end else if ((state == SRC_RUN) || cnt_zero) begin
            state_nxt = SRC_RUN;
            data_nxt  = run_data;
            dots_nxt  = run_dots;
            en_nxt    = 1'b1;
        end
`ifdef DISP_SCHED_BLINK_EN
        else if (state == SRC_MSG) begin
            if (blink_cnt == '0) begin
                en_nxt    = ~EN;
                blink_nxt = BLINK_W'(BLINK_HALF - 1);
            end else begin
                blink_nxt = blink_cnt - 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_200Hz or posedge rst) begin
        if (rst) begin
            state <= SRC_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_200Hz or posedge rst) begin
        if (rst) begin
            data    <= 16'h0000;
            dots    <= DOTS_BLANK;
            EN      <= 1'b0;
            lap_ack <= 1'b0;
            msg_ack <= 1'b0;
        end else begin
            data    <= data_nxt;
            dots    <= dots_nxt;
            EN      <= en_nxt;
            lap_ack <= lap_ack_nxt;
            msg_ack <= msg_ack_nxt;
        end
    end

`ifdef DISP_SCHED_BLINK_EN
    always_ff @(posedge clk_200Hz or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_nxt;
        end
    end
`endif

    assign src = state;

endmodule

// File: tb/tb_disp_sched.sv
// Self-checking bench for disp_sched: RUN vector table plus lap/msg/reset sequences.
module tb_disp_sched;

    localparam int HOLD  = 400;
    localparam int MSGT  = 600;
    localparam int BLINK = 40;

    logic        clk_200Hz = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] run_data, lap_data, msg_data;
    logic [3:0]  run_dots, msg_dots;
    logic        lap_req, msg_req;
    logic [15:0] data;
    logic [3:0]  dots;
    logic        EN, lap_ack, msg_ack;
    logic [1:0]  src;

    disp_sched #(.HOLD_TICKS(HOLD), .MSG_TICKS(MSGT), .BLINK_HALF(BLINK)) dut (
        .clk_200Hz (clk_200Hz),
        .rst       (rst),
        .run_data  (run_data),
        .run_dots  (run_dots),
        .lap_req   (lap_req),
        .lap_data  (lap_data),
        .msg_req   (msg_req),
        .msg_data  (msg_data),
        .msg_dots  (msg_dots),
        .data      (data),
        .dots      (dots),
        .EN        (EN),
        .lap_ack   (lap_ack),
        .msg_ack   (msg_ack),
        .src       (src)
    );

    always #5 clk_200Hz = ~clk_200Hz;

    // Observed bundle: data[24:9] dots[8:5] en[4] src[3:2] lap_ack[1] msg_ack[0]
    typedef logic [24:0] obs_t;

    typedef struct {
        logic [15:0] rd;
        logic [3:0]  rdots;
        logic [15:0] ed;
        logic [3:0]  edots;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    obs_t exp_q[$];
    vec_t vecs[5];

    function automatic obs_t mk(logic [15:0] d, logic [3:0] dt, logic en, logic [1:0] s,
                                logic la, logic ma);
        return {d, dt, en, s, la, ma};
    endfunction

    function automatic obs_t observed();
        return {data, dots, EN, src, lap_ack, msg_ack};
    endfunction

    function automatic logic msg_en(int k);
`ifdef DISP_SCHED_BLINK_EN
        return ((k / BLINK) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic compare(string name, obs_t got, obs_t want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t: got data=%h dots=%b en=%b src=%0d lap_ack=%b msg_ack=%b, want data=%h dots=%b en=%b src=%0d lap_ack=%b msg_ack=%b",
                     name, $time, got[24:9], got[8:5], got[4], got[3:2], got[1], got[0],
                     want[24:9], want[8:5], want[4], want[3:2], want[1], want[0]);
        end
    endtask

    task automatic step(string name, obs_t want);
        obs_t e;
        exp_q.push_back(want);
        @(posedge clk_200Hz);
        @(negedge clk_200Hz);
        e = exp_q.pop_front();
        compare(name, observed(), e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h1234, 4'b1111, 16'h1234, 4'b1111};
        vecs[1] = '{16'hABCD, 4'b0000, 16'hABCD, 4'b0000};
        vecs[2] = '{16'h0000, 4'b0101, 16'h0000, 4'b0101};
        vecs[3] = '{16'hFFFF, 4'b1010, 16'hFFFF, 4'b1010};
        vecs[4] = '{16'h9081, 4'b1110, 16'h9081, 4'b1110};

        lap_req  = 1'b0;
        msg_req  = 1'b0;
        run_data = 16'h0000;
        run_dots = 4'b1111;
        lap_data = 16'h0000;
        msg_data = 16'h0000;
        msg_dots = 4'b1111;

        #2 rst = 1'b1;
        #1 compare("reset_async", observed(), mk(16'h0000, 4'b1111, 1'b0, 2'd0, 1'b0, 1'b0));
        @(negedge clk_200Hz);
        compare("reset_hold", observed(), mk(16'h0000, 4'b1111, 1'b0, 2'd0, 1'b0, 1'b0));
        run_data = 16'h1234;
        rst = 1'b0;
        step("first_edge", mk(16'h1234, 4'b1111, 1'b1, 2'd0, 1'b0, 1'b0));

        for (int i = 0; i < 5; i++) begin
            run_data = vecs[i].rd;
            run_dots = vecs[i].rdots;
            step("run_table", mk(vecs[i].ed, vecs[i].edots, 1'b1, 2'd0, 1'b0, 1'b0));
        end

        // single-cycle lap request, 400-cycle hold, then back to live time
        run_data = 16'h5678;
        run_dots = 4'b1010;
        lap_data = 16'h0059;
        lap_req  = 1'b1;
        step("lap_accept", mk(16'h0059, 4'b1111, 1'b1, 2'd1, 1'b1, 1'b0));
        lap_req  = 1'b0;
        lap_data = 16'hDEAD;
        for (int k = 1; k < HOLD; k++)
            step("lap_hold", mk(16'h0059, 4'b1111, 1'b1, 2'd1, 1'b0, 1'b0));
        step("lap_exit", mk(16'h5678, 4'b1010, 1'b1, 2'd0, 1'b0, 1'b0));

        // new lap request during LAP re-latches and restarts the hold
        lap_data = 16'h0011;
        lap_req  = 1'b1;
        step("relatch_first", mk(16'h0011, 4'b1111, 1'b1, 2'd1, 1'b1, 1'b0));
        lap_req = 1'b0;
        for (int k = 1; k < 50; k++)
            step("relatch_hold1", mk(16'h0011, 4'b1111, 1'b1, 2'd1, 1'b0, 1'b0));
        lap_data = 16'h0088;
        lap_req  = 1'b1;
        step("relatch_second", mk(16'h0088, 4'b1111, 1'b1, 2'd1, 1'b1, 1'b0));
        lap_req = 1'b0;
        for (int k = 1; k < HOLD; k++)
            step("relatch_hold2", mk(16'h0088, 4'b1111, 1'b1, 2'd1, 1'b0, 1'b0));
        step("relatch_exit", mk(16'h5678, 4'b1010, 1'b1, 2'd0, 1'b0, 1'b0));

        // simultaneous requests: message first, lap pending until MSG ends
        lap_data = 16'h0042;
        lap_req  = 1'b1;
        msg_data = 16'hE0F0;
        msg_dots = 4'b0110;
        msg_req  = 1'b1;
        step("both_msg_first", mk(16'hE0F0, 4'b0110, msg_en(0), 2'd2, 1'b0, 1'b1));
        msg_req  = 1'b0;
        msg_data = 16'h0000;
        msg_dots = 4'b1111;
        for (int k = 1; k < MSGT; k++)
            step("both_msg_body", mk(16'hE0F0, 4'b0110, msg_en(k), 2'd2, 1'b0, 1'b0));
        step("both_msg_exit", mk(16'h5678, 4'b1010, 1'b1, 2'd0, 1'b0, 1'b0));
        step("both_lap_after", mk(16'h0042, 4'b1111, 1'b1, 2'd1, 1'b1, 1'b0));
        lap_req = 1'b0;
        for (int k = 1; k < HOLD; k++)
            step("both_lap_hold", mk(16'h0042, 4'b1111, 1'b1, 2'd1, 1'b0, 1'b0));
        step("both_lap_exit", mk(16'h5678, 4'b1010, 1'b1, 2'd0, 1'b0, 1'b0));

        // message preempts LAP 100 cycles in; lap hold is not resumed
        lap_data = 16'h0077;
        lap_req  = 1'b1;
        step("pre_lap_accept", mk(16'h0077, 4'b1111, 1'b1, 2'd1, 1'b1, 1'b0));
        lap_req = 1'b0;
        for (int k = 1; k < 100; k++)
            step("pre_lap_hold", mk(16'h0077, 4'b1111, 1'b1, 2'd1, 1'b0, 1'b0));
        msg_data = 16'hABCD;
        msg_dots = 4'b0000;
        msg_req  = 1'b1;
        step("pre_msg_accept", mk(16'hABCD, 4'b0000, msg_en(0), 2'd2, 1'b0, 1'b1));
        msg_req = 1'b0;
        for (int k = 1; k < MSGT; k++)
            step("pre_msg_body", mk(16'hABCD, 4'b0000, msg_en(k), 2'd2, 1'b0, 1'b0));
        step("pre_msg_exit", mk(16'h5678, 4'b1010, 1'b1, 2'd0, 1'b0, 1'b0));
        step("pre_no_lap_return", mk(16'h5678, 4'b1010, 1'b1, 2'd0, 1'b0, 1'b0));

        // reset 200 cycles into MSG
        msg_data = 16'h1357;
        msg_dots = 4'b0011;
        msg_req  = 1'b1;
        step("rst_msg_accept", mk(16'h1357, 4'b0011, msg_en(0), 2'd2, 1'b0, 1'b1));
        msg_req = 1'b0;
        for (int k = 1; k < 200; k++)
            step("rst_msg_body", mk(16'h1357, 4'b0011, msg_en(k), 2'd2, 1'b0, 1'b0));
        rst = 1'b1;
        #1 compare("rst_mid_async", observed(), mk(16'h0000, 4'b1111, 1'b0, 2'd0, 1'b0, 1'b0));
        @(negedge clk_200Hz);
        compare("rst_mid_hold", observed(), mk(16'h0000, 4'b1111, 1'b0, 2'd0, 1'b0, 1'b0));
        run_data = 16'h4321;
        rst = 1'b0;
        step("rst_release", mk(16'h4321, 4'b1010, 1'b1, 2'd0, 1'b0, 1'b0));
        step("rst_after", mk(16'h4321, 4'b1010, 1'b1, 2'd0, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
